// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers bus writes and offers one byte per frame
// through a registered write_enable/tx_data handshake paced by uart_tx_ready.
module uart_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  input  logic                  clear_overflow,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  busy,
  input  logic                  uart_tx_ready,
  output logic                  uart_write_enable,
  output logic [7:0]            uart_tx_data
);

  typedef enum logic [1:0] {IDLE, OFFER, DRAIN} state_t;

  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [7:0]          data_q, data_d;
  logic                ovf_q, ovf_d;
  logic                push, drop, pop;

  // Extra wrap bit distinguishes full (MSB differs) from empty (all equal).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign overflow          = ovf_q;
  assign busy              = (state_q != IDLE) || !empty;
  assign uart_write_enable = we_q;
  assign uart_tx_data      = data_q;

  always_comb begin
    push    = wr_en && !full && !flush;
    drop    = wr_en && (full || flush);
    pop     = 1'b0;
    state_d = state_q;
    we_d    = we_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (!empty && uart_tx_ready && !flush) begin
          state_d = OFFER;
          we_d    = 1'b1;
          data_d  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
      end
      OFFER: begin
        // Flush wins over a same-cycle acceptance so the byte is never counted as sent.
        if (flush) begin
          state_d = IDLE;
          we_d    = 1'b0;
        end else if (!uart_tx_ready) begin
          pop     = 1'b1;
          we_d    = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (uart_tx_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
      end
    endcase
    wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, push};
    rd_ptr_d = flush ? wr_ptr_q : (rd_ptr_q + {{ADDR_WIDTH{1'b0}}, pop});
    ovf_d    = drop ? 1'b1 : (clear_overflow ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
      we_q     <= 1'b0;
      data_q   <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      we_q     <= we_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed steps plus a randomized stream through a
// behavioural UART, checked against a queue model of the FIFO contents.
module tb_uart_tx_fifo;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int BAUD_DIV = 43;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          flush = 1'b0;
  logic          clear_overflow = 1'b0;
  logic          full, empty, overflow, busy;
  logic [AW:0]   level;
  logic          uart_tx_ready;
  logic          uart_write_enable;
  logic [7:0]    uart_tx_data;

  logic          manual_ready = 1'b1;
  logic          model_en = 1'b0;
  logic          model_ready;
  int            bcnt, bits;
  logic [7:0]    rx_q[$];
  logic [7:0]    mq[$];
  int            n_assert = 0;
  int            n_fail = 0;

  assign uart_tx_ready = model_en ? model_ready : manual_ready;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .clear_overflow(clear_overflow), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .busy(busy), .uart_tx_ready(uart_tx_ready),
    .uart_write_enable(uart_write_enable), .uart_tx_data(uart_tx_data)
  );

  always #5 clock = ~clock;

  // Transmitter: samples write_enable only on a baud tick while idle, then is busy for 10 bit times.
  always @(posedge clock) begin
    if (reset || !model_en) begin
      bcnt <= 0;
      bits <= 0;
      model_ready <= 1'b1;
    end else if (bcnt == BAUD_DIV - 1) begin
      bcnt <= 0;
      if (model_ready) begin
        if (uart_write_enable) begin
          rx_q.push_back(uart_tx_data);
          model_ready <= 1'b0;
          bits <= 10;
        end
      end else if (bits == 1) begin
        model_ready <= 1'b1;
        bits <= 0;
      end else begin
        bits <= bits - 1;
      end
    end else begin
      bcnt <= bcnt + 1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic serve_one();
    logic [7:0] exp_b;
    exp_b = mq.pop_front();
    manual_ready = 1'b1;
    for (int k = 0; k < 20 && !uart_write_enable; k++) step();
    check("serve_we", uart_write_enable, 1);
    check("serve_data", uart_tx_data, exp_b);
    manual_ready = 1'b0;
    step();
    check("serve_pop_we", uart_write_enable, 0);
    manual_ready = 1'b1;
    step();
  endtask

  initial begin
    logic [7:0] r;
    int pushed;
    int budget;
    #1 reset = 1'b1;
    step();
    step();
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_we", uart_write_enable, 0);
    check("rst_data", uart_tx_data, 8'h00);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    // Single byte into an empty FIFO with the transmitter idle.
    manual_ready = 1'b1;
    push_byte(8'hA5);
    check("t1_empty", empty, 0);
    check("t1_level", level, 1);
    check("t1_we_early", uart_write_enable, 0);
    step();
    check("t1_we", uart_write_enable, 1);
    check("t1_data", uart_tx_data, 8'hA5);
    step();
    check("t1_hold_we", uart_write_enable, 1);
    check("t1_hold_level", level, 1);
    manual_ready = 1'b0;
    step();
    check("t1_pop_we", uart_write_enable, 0);
    check("t1_pop_level", level, 0);
    check("t1_drain_busy", busy, 1);
    step();
    step();
    check("t1_drain_hold", busy, 1);
    check("t1_data_held", uart_tx_data, 8'hA5);
    manual_ready = 1'b1;
    step();
    check("t1_idle", busy, 0);

    // Fill to full with the transmitter busy, then overflow.
    manual_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push_byte(i[7:0]);
      mq.push_back(i[7:0]);
    end
    check("t2_full", full, 1);
    check("t2_level", level, DEPTH);
    push_byte(8'hFF);
    check("t2_ovf", overflow, 1);
    check("t2_level_kept", level, DEPTH);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    check("t2_ovf_clr", overflow, 0);

    // Push and pop in the same cycle while full: push is dropped.
    manual_ready = 1'b1;
    step();
    check("t4f_we", uart_write_enable, 1);
    check("t4f_data", uart_tx_data, mq[0]);
    manual_ready = 1'b0;
    push_byte(8'h77);
    void'(mq.pop_front());
    check("t4f_level", level, DEPTH - 1);
    check("t4f_ovf", overflow, 1);
    check("t4f_we_low", uart_write_enable, 0);
    clear_overflow = 1'b1;
    manual_ready = 1'b1;
    step();
    clear_overflow = 1'b0;
    while (mq.size() > 0) serve_one();
    check("t4f_drained", empty, 1);

    // Push and pop in the same cycle at level 5.
    manual_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r = 8'($urandom);
      push_byte(r);
      mq.push_back(r);
    end
    manual_ready = 1'b1;
    step();
    check("t4_data", uart_tx_data, mq[0]);
    manual_ready = 1'b0;
    r = 8'($urandom);
    push_byte(r);
    void'(mq.pop_front());
    mq.push_back(r);
    check("t4_level", level, 5);
    check("t4_ovf", overflow, 0);
    manual_ready = 1'b1;
    step();
    while (mq.size() > 0) serve_one();
    check("t4_drained", empty, 1);

    // Flush while offering.
    manual_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    manual_ready = 1'b1;
    step();
    check("t5_offer", uart_write_enable, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_we", uart_write_enable, 0);
    check("t5_level", level, 0);
    check("t5_idle", busy, 0);

    // Flush while a frame is in flight, with a push that must be dropped.
    manual_ready = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    manual_ready = 1'b1;
    step();
    manual_ready = 1'b0;
    step();
    check("t5d_level1", level, 1);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h33;
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    check("t5d_level", level, 0);
    check("t5d_busy", busy, 1);
    check("t5d_ovf", overflow, 1);
    step();
    check("t5d_busy_hold", busy, 1);
    manual_ready = 1'b1;
    step();
    check("t5d_idle", busy, 0);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;

    // Stream 40 random bytes through the behavioural transmitter.
    model_en = 1'b1;
    mq.delete();
    pushed = 0;
    budget = 60000;
    while ((pushed < 40 || rx_q.size() < 40) && budget > 0) begin
      if (pushed < 40 && (pushed - int'(rx_q.size())) < 14 && $urandom_range(0, 3) == 0) begin
        r = 8'($urandom);
        wr_en = 1'b1;
        wr_data = r;
        mq.push_back(r);
        pushed++;
      end else begin
        wr_en = 1'b0;
      end
      step();
      budget--;
    end
    wr_en = 1'b0;
    check("t3_count", rx_q.size(), 40);
    for (int i = 0; i < 40 && i < rx_q.size(); i++) check("t3_byte", rx_q[i], mq[i]);
    check("t3_ovf", overflow, 0);
    for (int k = 0; k < 600 && !model_ready; k++) step();
    model_en = 1'b0;
    manual_ready = 1'b1;
    step();
    step();

    // Asynchronous reset between edges while offering.
    manual_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    manual_ready = 1'b1;
    step();
    check("t6_offer", uart_write_enable, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_we", uart_write_enable, 0);
    check("t6_empty", empty, 1);
    check("t6_level", level, 0);
    step();
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
